j1_loader: RTL and testbench

J1_LOADER -- requirements
Module: j1_loader

---
 rtl/j1_loader.sv | 204 ++++++++++++++++++++
 tb/tb_j1_loader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/j1_loader.sv
// j1_loader: boot loader for the J1 CPU.
// Receives a framed program image over a valid/ready byte stream, writes it
// into instruction RAM and releases the CPU only after a matching checksum.
// Image: MAGIC, count (lo, hi), count x word (lo, hi), 8-bit sum of count+data bytes.
module j1_loader #(
    parameter logic [7:0]  MAGIC   = 8'hA5,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    input  logic        load_req_i,
    output logic        cpu_rst_o,
    output logic        pgm_we_o,
    output logic [12:0] pgm_addr_o,
    output logic [15:0] pgm_data_o,
    output logic        busy_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        WAIT_MAGIC,
        CNT_LO,
        CNT_HI,
        DATA_LO,
        DATA_HI,
        CSUM,
        RUN,
        ERR
    } state_t;

    // Largest image that fits the 13-bit instruction RAM.
    localparam logic [15:0] MAX_WORDS = 16'd8192;

    state_t      state;
    state_t      state_nxt;

    logic        accept;        // byte transfer on this cycle
    logic        loading;       // past MAGIC, image in progress
    logic        timeout_hit;   // idle limit reached without a byte
    logic [15:0] idle_cnt;
    logic [7:0]  csum;          // running sum of count and data bytes
    logic [12:0] word_idx;      // next RAM word to write
    logic [13:0] words_left;    // words still expected, 1..8192
    logic [7:0]  cnt_lo;        // captured low count byte
    logic [7:0]  data_lo;       // captured low data byte
    logic [15:0] count_full;

    // A word count is usable only if it is non-zero and fits the RAM.
    function automatic logic count_ok(input logic [15:0] cnt);
        return (cnt != 16'd0) && (cnt <= MAX_WORDS);
    endfunction

    assign loading      = (state == CNT_LO) || (state == CNT_HI) ||
                          (state == DATA_LO) || (state == DATA_HI) ||
                          (state == CSUM);
    assign byte_ready_o = (state != RUN) && (state != ERR);
    assign accept       = byte_valid_i && byte_ready_o;
    assign busy_o       = loading;
    assign cpu_rst_o    = (state != RUN);
    assign count_full   = {byte_data_i, cnt_lo};

    // A byte arriving on the limit cycle wins over the timeout.
    assign timeout_hit  = loading && !accept && (idle_cnt == TIMEOUT - 16'd1);

    // State register.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state <= WAIT_MAGIC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: byte-driven advance, plus timeout, ERR and reload exits.
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_MAGIC: begin
                if (accept && (byte_data_i == MAGIC)) begin
                    state_nxt = CNT_LO;
                end
            end
            CNT_LO: begin
                if (accept) begin
                    state_nxt = CNT_HI;
                end
            end
            CNT_HI: begin
                if (accept) begin
                    state_nxt = count_ok(count_full) ? DATA_LO : ERR;
                end
            end
            DATA_LO: begin
                if (accept) begin
                    state_nxt = DATA_HI;
                end
            end
            DATA_HI: begin
                if (accept) begin
                    state_nxt = (words_left == 14'd1) ? CSUM : DATA_LO;
                end
            end
            CSUM: begin
                if (accept) begin
                    state_nxt = (byte_data_i == csum) ? RUN : ERR;
                end
            end
            RUN: begin
                if (load_req_i) begin
                    state_nxt = WAIT_MAGIC;
                end
            end
            ERR: begin
                state_nxt = WAIT_MAGIC;
            end
            default: begin
                state_nxt = WAIT_MAGIC;
            end
        endcase
        if (timeout_hit) begin
            state_nxt = ERR;
        end
    end

    // Idle counter: runs only while an image is in progress, cleared by any accepted byte.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            idle_cnt <= 16'd0;
        end else if (!loading || accept || timeout_hit) begin
            idle_cnt <= 16'd0;
        end else begin
            idle_cnt <= idle_cnt + 16'd1;
        end
    end

    // Load datapath: checksum, word index, remaining count and RAM write port.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            csum       <= 8'd0;
            word_idx   <= 13'd0;
            words_left <= 14'd0;
            pgm_we_o   <= 1'b0;
            pgm_addr_o <= 13'd0;
            pgm_data_o <= 16'd0;
        end else begin
            pgm_we_o <= 1'b0;
            if (accept) begin
                case (state)
                    WAIT_MAGIC: begin
                        if (byte_data_i == MAGIC) begin
                            csum     <= 8'd0;
                            word_idx <= 13'd0;
                        end
                    end
                    CNT_LO: begin
                        csum <= csum + byte_data_i;
                    end
                    CNT_HI: begin
                        csum       <= csum + byte_data_i;
                        words_left <= count_full[13:0];
                    end
                    DATA_LO: begin
                        csum <= csum + byte_data_i;
                    end
                    DATA_HI: begin
                        csum       <= csum + byte_data_i;
                        pgm_we_o   <= 1'b1;
                        pgm_addr_o <= word_idx;
                        pgm_data_o <= {byte_data_i, data_lo};
                        word_idx   <= word_idx + 13'd1;
                        words_left <= words_left - 14'd1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Byte capture registers; only meaningful while their state is active.
    always_ff @(posedge sys_clk_i) begin
        if (accept && (state == CNT_LO)) begin
            cnt_lo <= byte_data_i;
        end
        if (accept && (state == DATA_LO)) begin
            data_lo <= byte_data_i;
        end
    end

    // Sticky error flag: set by a pass through ERR, cleared by a good checksum.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            err_o <= 1'b0;
        end else if (state == ERR) begin
            err_o <= 1'b1;
        end else if ((state == CSUM) && accept && (byte_data_i == csum)) begin
            err_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_j1_loader.sv
// Testbench for j1_loader: table of byte vectors with per-byte status
// expectations, a write scoreboard, and hand sequences for reload,
// timeout and mid-image reset.
module tb_j1_loader;

    localparam logic [15:0] TOUT = 16'd20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        ready;
    logic        load_req = 1'b0;
    logic        cpu_rst;
    logic        we;
    logic [12:0] addr;
    logic [15:0] wdata;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    j1_loader #(.MAGIC(8'hA5), .TIMEOUT(TOUT)) dut (
        .sys_clk_i    (clk),
        .sys_rst_i    (rst),
        .byte_valid_i (valid),
        .byte_data_i  (data),
        .byte_ready_o (ready),
        .load_req_i   (load_req),
        .cpu_rst_o    (cpu_rst),
        .pgm_we_o     (we),
        .pgm_addr_o   (addr),
        .pgm_data_o   (wdata),
        .busy_o       (busy),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t sb_q[$];

    typedef struct {
        logic [7:0]  data;
        int          gap;
        logic        push;
        logic [12:0] waddr;
        logic [15:0] wdata;
        logic        busy;
        logic        ready;
        logic        cpu;
        logic        err;
    } vec_t;

    vec_t tbl [0:22];

    function automatic vec_t mk(input logic [7:0] d, input int g, input logic p,
                                input logic [12:0] wa, input logic [15:0] wd,
                                input logic b, input logic r, input logic c, input logic e);
        vec_t v;
        v.data = d; v.gap = g; v.push = p; v.waddr = wa; v.wdata = wd;
        v.busy = b; v.ready = r; v.cpu = c; v.err = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [12:0] a, input logic [15:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        sb_q.push_back(w);
    endtask

    // Idle for gap cycles, wait (bounded) for ready, then transfer one byte.
    task automatic send(input logic [7:0] b, input int gap);
        int w;
        valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        w = 0;
        while (!ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_wait actual=0 expected=1");
        end
        valid = 1'b1;
        data  = b;
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (tbl[i].push) push_wr(tbl[i].waddr, tbl[i].wdata);
            send(tbl[i].data, tbl[i].gap);
            chk($sformatf("row%0d_busy", i),  busy,    tbl[i].busy);
            chk($sformatf("row%0d_ready", i), ready,   tbl[i].ready);
            chk($sformatf("row%0d_cpu", i),   cpu_rst, tbl[i].cpu);
            chk($sformatf("row%0d_err", i),   err,     tbl[i].err);
        end
    endtask

    // Good two-word image: checksum = (02+00+34+12+CD+AB) mod 256 = C0.
    task automatic send_good_image();
        send(8'hA5, 0); send(8'h02, 0); send(8'h00, 0);
        push_wr(13'd0, 16'h1234);
        send(8'h34, 0); send(8'h12, 0);
        push_wr(13'd1, 16'hABCD);
        send(8'hCD, 0); send(8'hAB, 0);
        send(8'hC0, 0);
    endtask

    // Write monitor: every strobe must match the oldest expected write and last one cycle.
    logic we_prev = 1'b0;
    always @(negedge clk) begin
        if (we === 1'b1) begin
            wr_t e;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0h data=%0h expected=none", addr, wdata);
            end else begin
                e = sb_q.pop_front();
                if (addr !== e.addr || wdata !== e.data) begin
                    errors++;
                    $display("FAIL write addr=%0h data=%0h expected addr=%0h data=%0h",
                             addr, wdata, e.addr, e.data);
                end
            end
            checks++;
            if (we_prev === 1'b1) begin
                errors++;
                $display("FAIL we_width actual=2+ cycles expected=1");
            end
        end
        we_prev = we;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // data, gap, push, waddr, wdata, busy, ready, cpu, err (after accept)
        tbl[0]  = mk(8'h00, 2, 0, 0, 0,          0, 1, 1, 0);
        tbl[1]  = mk(8'hFF, 0, 0, 0, 0,          0, 1, 1, 0);
        tbl[2]  = mk(8'hA5, 0, 0, 0, 0,          1, 1, 1, 0);
        tbl[3]  = mk(8'h02, 0, 0, 0, 0,          1, 1, 1, 0);
        tbl[4]  = mk(8'h00, 0, 0, 0, 0,          1, 1, 1, 0);
        tbl[5]  = mk(8'h34, 0, 0, 0, 0,          1, 1, 1, 0);
        tbl[6]  = mk(8'h12, 0, 1, 0, 16'h1234,   1, 1, 1, 0);
        tbl[7]  = mk(8'hCD, 0, 0, 0, 0,          1, 1, 1, 0);
        tbl[8]  = mk(8'hAB, 0, 1, 1, 16'hABCD,   1, 1, 1, 0);
        tbl[9]  = mk(8'hC0, 0, 0, 0, 0,          0, 0, 0, 0);
        // bad checksum image
        tbl[10] = mk(8'hA5, 0, 0, 0, 0,          1, 1, 1, 0);
        tbl[11] = mk(8'h02, 0, 0, 0, 0,          1, 1, 1, 0);
        tbl[12] = mk(8'h00, 0, 0, 0, 0,          1, 1, 1, 0);
        tbl[13] = mk(8'h34, 0, 0, 0, 0,          1, 1, 1, 0);
        tbl[14] = mk(8'h12, 0, 1, 0, 16'h1234,   1, 1, 1, 0);
        tbl[15] = mk(8'hCD, 0, 0, 0, 0,          1, 1, 1, 0);
        tbl[16] = mk(8'hAB, 0, 1, 1, 16'hABCD,   1, 1, 1, 0);
        tbl[17] = mk(8'hC1, 0, 0, 0, 0,          0, 0, 1, 0);
        // count 0, then count 8193; err now sticky from the bad checksum
        tbl[18] = mk(8'hA5, 1, 0, 0, 0,          1, 1, 1, 1);
        tbl[19] = mk(8'h00, 0, 0, 0, 0,          1, 1, 1, 1);
        tbl[20] = mk(8'h00, 0, 0, 0, 0,          0, 0, 1, 1);
        tbl[21] = mk(8'hA5, 1, 0, 0, 0,          1, 1, 1, 1);
        tbl[22] = mk(8'h01, 0, 0, 0, 0,          1, 1, 1, 1);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ready", ready, 1);
        chk("rst_cpu",   cpu_rst, 1);
        chk("rst_we",    we, 0);
        chk("rst_addr",  addr, 0);
        chk("rst_data",  wdata, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_err",   err, 0);

        // Junk then good image
        run_rows(0, 9);

        // RUN holds, outputs hold, then reload request
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("run_cpu",   cpu_rst, 0);
        chk("run_ready", ready, 0);
        chk("hold_addr", addr, 13'd1);
        chk("hold_data", wdata, 16'hABCD);
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
        chk("reload_cpu",   cpu_rst, 1);
        chk("reload_ready", ready, 1);
        chk("reload_busy",  busy, 0);

        // Bad checksum, count 0, count 8193
        run_rows(10, 22);
        send(8'h20, 0);
        chk("cnt8193_ready", ready, 0);
        chk("cnt8193_busy",  busy, 0);
        chk("cnt8193_cpu",   cpu_rst, 1);

        // Stall of TIMEOUT-1 cycles then a byte: load continues and succeeds
        send(8'hA5, 1); send(8'h02, 0); send(8'h00, 0); send(8'h34, 0);
        push_wr(13'd0, 16'h1234);
        send(8'h12, int'(TOUT) - 1);
        chk("stall_ok_busy", busy, 1);
        push_wr(13'd1, 16'hABCD);
        send(8'hCD, 0); send(8'hAB, 0);
        send(8'hC0, 0);
        chk("stall_ok_cpu", cpu_rst, 0);
        chk("stall_ok_err", err, 0);
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;

        // Stall of TIMEOUT cycles after first data byte: error
        send(8'hA5, 0); send(8'h02, 0); send(8'h00, 0); send(8'h34, 0);
        repeat (int'(TOUT) - 1) begin
            @(posedge clk); #1;
        end
        chk("to_not_yet_busy", busy, 1);
        @(posedge clk); #1;
        chk("to_err_busy",  busy, 0);
        chk("to_err_ready", ready, 0);
        chk("to_err_cpu",   cpu_rst, 1);
        @(posedge clk); #1;
        chk("to_err_flag",  err, 1);
        chk("to_wait_ready", ready, 1);

        // Reset in the middle of the data phase
        send(8'hA5, 0); send(8'h03, 0); send(8'h00, 0);
        push_wr(13'd0, 16'h2211);
        send(8'h11, 0); send(8'h22, 0);
        push_wr(13'd1, 16'h4433);
        send(8'h33, 0); send(8'h44, 0);
        send(8'h55, 0);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_ready", ready, 1);
        chk("midrst_cpu",   cpu_rst, 1);
        chk("midrst_we",    we, 0);
        chk("midrst_addr",  addr, 0);
        chk("midrst_data",  wdata, 0);
        chk("midrst_busy",  busy, 0);
        chk("midrst_err",   err, 0);
        send_good_image();
        chk("after_rst_cpu", cpu_rst, 0);
        chk("after_rst_err", err, 0);

        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("sb_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
